// File: rtl/frog_turn_controller.sv
// Turn sequencer for the three player frogs: spawn, play, home or die, respawn.
// Tracks the three home slots and hands play to the next frog after a home landing.
module frog_turn_controller #(
    parameter int          RESPAWN_FRAMES = 30,
    parameter logic [10:0] HOME_Y         = 11'd40,
    parameter logic [10:0] HOME_X0        = 11'd120,
    parameter logic [10:0] HOME_X1        = 11'd280,
    parameter logic [10:0] HOME_X2        = 11'd480
) (
    input  logic        frame_clk,
    input  logic        game_restart,
    input  logic [10:0] frog_x,
    input  logic [10:0] frog_y,
    input  logic        dead_frog,
    input  logic        game_over,
    output logic [1:0]  active_frog,
    output logic [2:0]  frog_enable,
    output logic [2:0]  respawn,
    output logic [2:0]  home_filled,
    output logic        all_home
);

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        PLAY,
        HOMED,
        DYING,
        DONE
    } state_t;

    localparam logic [7:0] DYING_LOAD = 8'(RESPAWN_FRAMES - 1);

    state_t      state;
    state_t      state_next;
    logic [1:0]  active_next;
    logic [2:0]  home_next;
    logic [7:0]  count;
    logic [7:0]  count_next;
    logic        on_home_row;
    logic [2:0]  slot_match;
    logic [2:0]  home_hit;

    function automatic logic [2:0] frog_onehot(input logic [1:0] idx);
        logic [2:0] result;
        result = 3'b000;
        case (idx)
            2'd0:    result = 3'b001;
            2'd1:    result = 3'b010;
            2'd2:    result = 3'b100;
            default: result = 3'b000;
        endcase
        return result;
    endfunction

    // An already-occupied slot never matches, so landing there counts as a bad landing.
    always_comb begin
        on_home_row = (frog_y == HOME_Y);
        slot_match  = {frog_x == HOME_X2, frog_x == HOME_X1, frog_x == HOME_X0};
        home_hit    = on_home_row ? (slot_match & ~home_filled) : 3'b000;
    end

    always_comb begin
        state_next  = state;
        active_next = active_frog;
        home_next   = home_filled;
        count_next  = count;
        if (game_over) begin
            state_next = DONE;
        end else begin
            case (state)
                IDLE: begin
                    state_next = SPAWN;
                end
                SPAWN: begin
                    state_next = PLAY;
                end
                PLAY: begin
                    if (|home_hit) begin
                        home_next  = home_filled | home_hit;
                        state_next = HOMED;
                    end else if (dead_frog || on_home_row) begin
                        count_next = DYING_LOAD;
                        state_next = DYING;
                    end
                end
                HOMED: begin
                    if (&home_filled) begin
                        state_next = DONE;
                    end else begin
                        active_next = (active_frog == 2'd2) ? 2'd0 : active_frog + 2'd1;
                        state_next  = SPAWN;
                    end
                end
                DYING: begin
                    if (count == 8'd0) begin
                        state_next = SPAWN;
                    end else begin
                        count_next = count - 8'd1;
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next-state values so they line up with the state they describe.
    always_ff @(posedge frame_clk) begin
        if (game_restart) begin
            state       <= IDLE;
            active_frog <= 2'd0;
            home_filled <= 3'b000;
            count       <= 8'd0;
            frog_enable <= 3'b000;
            respawn     <= 3'b000;
            all_home    <= 1'b0;
        end else begin
            state       <= state_next;
            active_frog <= active_next;
            home_filled <= home_next;
            count       <= count_next;
            frog_enable <= (state_next == PLAY)  ? frog_onehot(active_next) : 3'b000;
            respawn     <= (state_next == SPAWN) ? frog_onehot(active_next) : 3'b000;
            all_home    <= &home_next;
        end
    end

endmodule

// File: tb/tb_frog_turn_controller.sv
// Self-checking bench for frog_turn_controller: directed frame-accurate scenarios
// followed by randomized play, all checked against an event-schedule model.
module tb_frog_turn_controller;

    localparam int          RESPAWN = 30;
    localparam logic [10:0] HOME_Y  = 11'd40;

    logic        frame_clk;
    logic        game_restart;
    logic [10:0] frog_x;
    logic [10:0] frog_y;
    logic        dead_frog;
    logic        game_over;
    logic [1:0]  active_frog;
    logic [2:0]  frog_enable;
    logic [2:0]  respawn;
    logic [2:0]  home_filled;
    logic        all_home;

    int checks_done = 0;
    int fail_count  = 0;

    frog_turn_controller #(
        .RESPAWN_FRAMES(RESPAWN),
        .HOME_Y(HOME_Y),
        .HOME_X0(11'd120),
        .HOME_X1(11'd280),
        .HOME_X2(11'd480)
    ) dut (
        .frame_clk(frame_clk),
        .game_restart(game_restart),
        .frog_x(frog_x),
        .frog_y(frog_y),
        .dead_frog(dead_frog),
        .game_over(game_over),
        .active_frog(active_frog),
        .frog_enable(frog_enable),
        .respawn(respawn),
        .home_filled(home_filled),
        .all_home(all_home)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks_done++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Event-schedule model: the frog is either playing, spawning, done, or waiting
    // a number of frames for the next scheduled spawn/finish.
    int         home_xs [3] = '{120, 280, 480};
    bit         m_done   = 0;
    bit         m_play   = 0;
    bit         m_spawn  = 0;
    bit         m_finish = 0;
    bit         m_advance = 0;
    int         m_wait   = 0;
    int         m_frog   = 0;
    logic [2:0] m_slots  = 3'b000;

    task automatic model_step();
        int hit;
        if (game_restart) begin
            m_done = 0; m_play = 0; m_spawn = 0; m_finish = 0; m_advance = 0;
            m_slots = 3'b000; m_frog = 0; m_wait = 1;
        end else if (game_over) begin
            m_done = 1; m_play = 0; m_spawn = 0; m_finish = 0; m_advance = 0; m_wait = 0;
        end else if (m_done) begin
            m_wait = 0;
        end else if (m_spawn) begin
            m_spawn = 0;
            m_play  = 1;
        end else if (m_play) begin
            hit = -1;
            for (int i = 0; i < 3; i++)
                if (frog_y == HOME_Y && int'(frog_x) == home_xs[i] && !m_slots[i]) hit = i;
            if (hit >= 0) begin
                m_slots[hit] = 1'b1;
                m_play = 0;
                m_wait = 1;
                if (m_slots == 3'b111) m_finish = 1;
                else                   m_advance = 1;
            end else if (dead_frog || frog_y == HOME_Y) begin
                m_play = 0;
                m_wait = RESPAWN;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                if (m_finish) m_done = 1;
                else begin
                    m_spawn = 1;
                    if (m_advance) m_frog = (m_frog + 1) % 3;
                end
                m_finish = 0;
                m_advance = 0;
            end
        end
    endtask

    always @(posedge frame_clk) begin
        model_step();
        #1;
        check_output("model active_frog", 16'(active_frog), 16'(m_frog));
        check_output("model frog_enable", 16'(frog_enable), m_play  ? 16'(1 << m_frog) : 16'd0);
        check_output("model respawn",     16'(respawn),     m_spawn ? 16'(1 << m_frog) : 16'd0);
        check_output("model home_filled", 16'(home_filled), 16'(m_slots));
        check_output("model all_home",    16'(all_home),    16'(&m_slots));
    end

    task automatic apply_stimulus(input logic rst, input int x, input int y, input logic dead, input logic over);
        game_restart = rst;
        frog_x       = 11'(x);
        frog_y       = 11'(y);
        dead_frog    = dead;
        game_over    = over;
    endtask

    task automatic frames(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    initial begin
        apply_stimulus(1, 0, 200, 0, 0);
        frames(1);
        // Reset then IDLE, SPAWN pulse for frog 0, then play.
        check_output("reset active_frog", 16'(active_frog), 16'd0);
        check_output("reset frog_enable", 16'(frog_enable), 16'd0);
        check_output("reset home_filled", 16'(home_filled), 16'd0);
        check_output("reset respawn",     16'(respawn),     16'd0);
        apply_stimulus(0, 0, 200, 0, 0);
        frames(1);
        check_output("first respawn", 16'(respawn), 16'b001);
        check_output("first enable during spawn", 16'(frog_enable), 16'b000);
        frames(1);
        check_output("first play enable", 16'(frog_enable), 16'b001);

        // Frog 0 homes in slot 1; frog 1 spawns two frames later.
        apply_stimulus(0, 280, 40, 0, 0);
        frames(1);
        check_output("homed slot1", 16'(home_filled), 16'b010);
        check_output("homed enable", 16'(frog_enable), 16'b000);
        apply_stimulus(0, 0, 200, 0, 0);
        frames(1);
        check_output("next frog respawn", 16'(respawn), 16'b010);
        check_output("next frog index", 16'(active_frog), 16'd1);
        frames(1);
        check_output("frog1 play", 16'(frog_enable), 16'b010);

        // One-frame death: exactly RESPAWN frames of DYING, same frog respawns.
        apply_stimulus(0, 0, 200, 1, 0);
        frames(1);
        check_output("dying enable", 16'(frog_enable), 16'b000);
        apply_stimulus(0, 0, 200, 0, 0);
        frames(RESPAWN - 1);
        check_output("last dying frame respawn", 16'(respawn), 16'b000);
        frames(1);
        check_output("death respawn", 16'(respawn), 16'b010);
        check_output("death same frog", 16'(active_frog), 16'd1);
        frames(1);

        // Landing on the occupied slot 1 counts as a death.
        apply_stimulus(0, 280, 40, 0, 0);
        frames(1);
        check_output("bad landing enable", 16'(frog_enable), 16'b000);
        check_output("bad landing slots", 16'(home_filled), 16'b010);
        apply_stimulus(0, 0, 200, 0, 0);
        frames(RESPAWN);
        check_output("bad landing respawn", 16'(respawn), 16'b010);
        frames(1);

        // Home hit together with dead_frog: the home landing wins.
        apply_stimulus(0, 120, 40, 1, 0);
        frames(1);
        check_output("home beats death", 16'(home_filled), 16'b011);
        apply_stimulus(0, 0, 200, 0, 0);
        frames(1);
        check_output("frog2 respawn", 16'(respawn), 16'b100);
        frames(1);

        // Last slot fills: all_home, DONE, frog 2 held.
        apply_stimulus(0, 480, 40, 0, 0);
        frames(1);
        check_output("all slots", 16'(home_filled), 16'b111);
        apply_stimulus(0, 0, 200, 0, 0);
        frames(3);
        check_output("done all_home", 16'(all_home), 16'd1);
        check_output("done enable", 16'(frog_enable), 16'b000);
        check_output("done active", 16'(active_frog), 16'd2);

        // Restart, die, then restart again in the middle of DYING.
        apply_stimulus(1, 0, 200, 0, 0);
        frames(1);
        apply_stimulus(0, 0, 200, 0, 0);
        frames(2);
        apply_stimulus(0, 0, 200, 1, 0);
        frames(1);
        apply_stimulus(0, 0, 200, 0, 0);
        frames(17);
        apply_stimulus(1, 0, 200, 0, 0);
        frames(1);
        check_output("mid-dying reset slots", 16'(home_filled), 16'd0);
        check_output("mid-dying reset respawn", 16'(respawn), 16'd0);
        apply_stimulus(0, 0, 200, 0, 0);
        frames(1);
        check_output("post reset spawn", 16'(respawn), 16'b001);
        frames(1);

        // game_over together with a home hit: DONE and no slot recorded.
        apply_stimulus(0, 120, 40, 0, 1);
        frames(1);
        check_output("game_over no slot", 16'(home_filled), 16'd0);
        check_output("game_over enable", 16'(frog_enable), 16'd0);
        apply_stimulus(0, 0, 200, 0, 0);
        frames(2);

        // Randomized play against the model.
        for (int n = 0; n < 4000; n++) begin
            int x;
            int y;
            x = ($urandom_range(3, 0) != 0) ? home_xs[$urandom_range(2, 0)] : int'($urandom_range(600, 0));
            y = ($urandom_range(3, 0) == 0) ? 40 : int'($urandom_range(400, 0));
            apply_stimulus($urandom_range(79, 0) == 0, x, y,
                           $urandom_range(15, 0) == 0, $urandom_range(249, 0) == 0);
            frames(1);
        end

        apply_stimulus(0, 0, 200, 0, 0);
        frames(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
        $finish;
    end

endmodule
